lector_destinos: RTL and testbench
==================================

# lector_destinos

Drain-side consumer for the transmission-layer datapath. It pops words from the two destination FIFOs (D0, D1) through their `Dx_pop` / `empty_fifo_Dx` / `data_out_Dx` interface. It arbitrates round-robin between them and presents one word at a time downstream with a valid/ready handshake. It also keeps per-destination word counters and a sticky routing-error flag, so benches can check end-to-end delivery of traffic pushed in at `data_in`.

## Interface
Parameters:
- `DATA_WIDTH`, 6, word width; matches the D0/D1 FIFO width.
- `CNT_WIDTH`, 8, width of each per-destination word counter.
- `ROUTE_BIT`, 4, index of the word bit that encodes the destination (0 = D0, 1 = D1).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `enable` input 1: allows new pops; does not abort a transfer already in flight.
- `empty_fifo_D0`, `empty_fifo_D1` input 1 each: destination FIFO empty flags.
- `data_out_D0`, `data_out_D1` input DATA_WIDTH each: FIFO read data, valid the cycle after the corresponding pop.
- `D0_pop`, `D1_pop` output 1 each: combinational pop strobes; never both high.
- `data_out` output DATA_WIDTH: captured word.
- `valid_out` output 1: `data_out` holds a word not yet accepted.
- `dest_out` output 1: source FIFO of `data_out` (0 = D0, 1 = D1).
- `ready_in` input 1: downstream accepts the word when `valid_out & ready_in`.
- `count_D0`, `count_D1` output CNT_WIDTH each: words captured from each FIFO.
- `error_route` output 1: sticky; a captured word's `ROUTE_BIT` differed from its source FIFO.
- `idle_out` output 1: state IDLE and both FIFOs empty.

## Operation
- FSM states: IDLE, CAPTURE, HOLD, all registered.
- **Pop condition** (`can_pop`): `enable & (!empty_fifo_D0 | !empty_fifo_D1)`.
- **IDLE:**
  - If `can_pop`, the chosen `Dx_pop` is high this cycle, `pend_dest` is latched, and the next state is CAPTURE.
  - Otherwise stay in IDLE.
- **CAPTURE:**
  - `data_out_D[pend_dest]` is registered into `data_out`, and `dest_out <= pend_dest`.
  - `valid_out <= 1`.
  - `count_D[pend_dest]` increments.
  - If `data[ROUTE_BIT] != pend_dest`, `error_route <= 1`.
  - Next state is HOLD. No pop is issued in CAPTURE.
- **HOLD:**
  - While `!ready_in`, `data_out` and `dest_out` are stable and `valid_out` stays 1.
  - On `ready_in`, if `can_pop`, the next pop is issued in the same cycle and the next state is CAPTURE, with `valid_out <= 0`.
  - On `ready_in` without `can_pop`, the next state is IDLE, with `valid_out <= 0`.
- **Round-robin arbitration:**
  - Register `last` records the most recently popped FIFO.
  - If both FIFOs are non-empty, pop the one that is not `last`.
  - If only one is non-empty, pop that one.
  - `last` updates on every pop.
- **Counters:** increment by 1 and wrap modulo 2^CNT_WIDTH (255 → 0 at the default width). There is no saturation.
- **`error_route`:** cleared only by `reset`.
- **`enable` deasserted:** no new pops are issued. A CAPTURE in progress completes, and HOLD waits for `ready_in` as usual.
- **Pop strobes:** a pop is never issued to a FIFO whose empty flag is 1 in the same cycle.

## Timing
- **Reset values** (async assertion, immediate effect):
  - state IDLE, `last` = 1 (so D0 wins the first tie);
  - `data_out` 0, `dest_out` 0, `valid_out` 0;
  - `count_D0` 0, `count_D1` 0, `error_route` 0;
  - `D0_pop` = `D1_pop` = 0 while `reset` is high.
- **Reset mid-operation:** any pending or held word is dropped and is not counted beyond what was already captured. The first pop after release follows the round-robin tie rule with D0 preferred.
- **Latency:** pop at cycle t, FIFO data at t+1, registered at the edge ending t+1, `valid_out` high from t+2.
- **Throughput:** at most one word per 2 cycles, when `ready_in` is held high.
- **Pop issued in HOLD:** the handshake completes in the same cycle the pop is issued; `valid_out` is low for exactly one cycle (CAPTURE) before the next word.
- **Empty flag rises in the pop cycle:** a FIFO whose empty flag goes high in the same cycle as its pop is not popped; the decision uses the current-cycle flag.
- **Counter wrap** occurs on the capture edge.

## Test plan
1. **Single word:** reset, `enable` = 1, push 0x12 (bit4 = 1) into D1 only, `ready_in` = 1.
   - Expect `D1_pop` for 1 cycle, `data_out` = 0x12 with `dest_out` = 1 and `valid_out` high 2 cycles later.
   - Expect `count_D1` = 1 and `error_route` = 0.
2. **Round-robin:** D0 holds 0x01, 0x02 and D1 holds 0x11, 0x12, `ready_in` = 1.
   - Expect output order 0x01, 0x11, 0x02, 0x12, one word per 2 cycles.
   - Expect `count_D0` = `count_D1` = 2 and `idle_out` = 1 at the end.
3. **Backpressure:** hold `ready_in` = 0 for 5 cycles with a word valid.
   - Expect `data_out` and `valid_out` stable and no pops.
   - On release, expect the handshake and the next pop in the same cycle.
4. **Route error:** D0 delivers 0x10.
   - Expect `error_route` = 1 from the capture edge, and it stays 1 after later good words until `reset`.
5. **Wrap and enable:** capture 256 D0 words.
   - Expect `count_D0` = 0 afterwards.
   - Deassert `enable` during CAPTURE: the word is still delivered, and no further pop occurs while FIFOs are non-empty.
6. **Reset mid-HOLD:** assert `reset` while `valid_out` = 1.
   - Expect `valid_out`, both counters, and `error_route` to read 0 immediately.

Source files
------------

// File: rtl/lector_destinos.sv
// lector_destinos: round-robin drain of the D0/D1 destination FIFOs into a valid/ready word stream
module lector_destinos #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8,
    parameter int ROUTE_BIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic [DATA_WIDTH-1:0] data_out_D0,
    input  logic [DATA_WIDTH-1:0] data_out_D1,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  dest_out,
    input  logic                  ready_in,
    output logic [CNT_WIDTH-1:0]  count_D0,
    output logic [CNT_WIDTH-1:0]  count_D1,
    output logic                  error_route,
    output logic                  idle_out
);
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    state_t                state;
    logic                  last;
    logic                  pend_dest;
    logic                  can_pop;
    logic                  pop_go;
    logic                  sel;
    logic [DATA_WIDTH-1:0] word;

    assign can_pop  = enable & (!empty_fifo_D0 | !empty_fifo_D1);
    // On a tie take the FIFO not popped last; otherwise the only non-empty one.
    assign sel      = (!empty_fifo_D0 & !empty_fifo_D1) ? !last : empty_fifo_D0;
    // Pops only from IDLE or from HOLD in the same cycle the held word is accepted.
    assign pop_go   = !reset & can_pop & ((state == IDLE) | ((state == HOLD) & ready_in));
    assign D0_pop   = pop_go & !sel;
    assign D1_pop   = pop_go & sel;
    assign word     = pend_dest ? data_out_D1 : data_out_D0;
    assign idle_out = (state == IDLE) & empty_fifo_D0 & empty_fifo_D1;

    // Pop / capture / hold sequencing with counters and sticky route check.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            pend_dest   <= 1'b0;
            data_out    <= '0;
            dest_out    <= 1'b0;
            valid_out   <= 1'b0;
            count_D0    <= '0;
            count_D1    <= '0;
            error_route <= 1'b0;
        end else begin
            if (pop_go) begin
                pend_dest <= sel;
                last      <= sel;
            end
            case (state)
                IDLE: if (pop_go) state <= CAPTURE;
                CAPTURE: begin
                    data_out  <= word;
                    dest_out  <= pend_dest;
                    valid_out <= 1'b1;
                    if (pend_dest) count_D1 <= count_D1 + CNT_WIDTH'(1);
                    else count_D0 <= count_D0 + CNT_WIDTH'(1);
                    if (word[ROUTE_BIT] != pend_dest) error_route <= 1'b1;
                    state <= HOLD;
                end
                HOLD: if (ready_in) begin
                    valid_out <= 1'b0;
                    state     <= pop_go ? CAPTURE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lector_destinos.sv
// tb_lector_destinos: directed scenarios for lector_destinos with behavioural D0/D1 FIFOs
module tb_lector_destinos;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ready_in = 1'b0;
    logic       mask0 = 1'b0;
    logic       empty_fifo_D0, empty_fifo_D1;
    logic [5:0] data_out_D0, data_out_D1;
    logic       D0_pop, D1_pop;
    logic [5:0] data_out;
    logic       valid_out, dest_out, error_route, idle_out;
    logic [7:0] count_D0, count_D1;

    logic [5:0] m0 [0:511];
    logic [5:0] m1 [0:511];
    int w0 = 0, w1 = 0, r0, r1;
    int pass_n = 0, total_n = 0;

    lector_destinos dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .valid_out(valid_out), .dest_out(dest_out),
        .ready_in(ready_in), .count_D0(count_D0), .count_D1(count_D1),
        .error_route(error_route), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    assign empty_fifo_D0 = (w0 == r0) || mask0;
    assign empty_fifo_D1 = (w1 == r1);

    // FIFO read side: data appears the cycle after a pop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r0 <= 0;
            r1 <= 0;
            data_out_D0 <= '0;
            data_out_D1 <= '0;
        end else begin
            if (D0_pop) begin
                data_out_D0 <= m0[r0];
                r0 <= r0 + 1;
            end
            if (D1_pop) begin
                data_out_D1 <= m1[r1];
                r1 <= r1 + 1;
            end
        end
    end

    task automatic push0(input logic [5:0] v);
        m0[w0] = v;
        w0 = w0 + 1;
    endtask

    task automatic push1(input logic [5:0] v);
        m1[w1] = v;
        w1 = w1 + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        ready_in = 1'b0;
        mask0 = 1'b0;
        w0 = 0;
        w1 = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        enable = 1'b1;
        push0(6'h05);
        #1;
        total_n++;
        if ({D0_pop, D1_pop} !== 2'b00) $display("FAIL reset_pops: got %b want 00", {D0_pop, D1_pop});
        else pass_n++;
        total_n++;
        if ({valid_out, dest_out, data_out} !== 8'h00) $display("FAIL reset_out: got %h want 00", {valid_out, dest_out, data_out});
        else pass_n++;
        total_n++;
        if ({count_D0, count_D1, error_route} !== 17'h0) $display("FAIL reset_cnt: got %h want 0", {count_D0, count_D1, error_route});
        else pass_n++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        push1(6'h12);
        #1;
        total_n++;
        if ({D0_pop, D1_pop} !== 2'b01) $display("FAIL single_pop: got %b want 01", {D0_pop, D1_pop});
        else pass_n++;
        @(negedge clk);
        total_n++;
        if ({valid_out, D0_pop, D1_pop} !== 3'b000) $display("FAIL single_capture: got %b want 000", {valid_out, D0_pop, D1_pop});
        else pass_n++;
        @(negedge clk);
        total_n++;
        if ({valid_out, dest_out, data_out} !== {2'b11, 6'h12}) $display("FAIL single_word: got %h want %h", {valid_out, dest_out, data_out}, {2'b11, 6'h12});
        else pass_n++;
        total_n++;
        if ({count_D1, error_route} !== {8'd1, 1'b0}) $display("FAIL single_cnt: got %h want %h", {count_D1, error_route}, {8'd1, 1'b0});
        else pass_n++;
        @(negedge clk);
        total_n++;
        if ({valid_out, idle_out} !== 2'b01) $display("FAIL single_idle: got %b want 01", {valid_out, idle_out});
        else pass_n++;
    endtask

    task automatic test_round_robin();
        logic [5:0] exp [4];
        exp = '{6'h01, 6'h11, 6'h02, 6'h12};
        do_reset();
        push0(6'h01);
        push0(6'h02);
        push1(6'h11);
        push1(6'h12);
        enable = 1'b1;
        ready_in = 1'b1;
        #1;
        total_n++;
        if ({D0_pop, D1_pop} !== 2'b10) $display("FAIL rr_first: got %b want 10", {D0_pop, D1_pop});
        else pass_n++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                total_n++;
                if (valid_out !== 1'b0) $display("FAIL rr_gap%0d: got %b want 0", k, valid_out);
                else pass_n++;
            end
            @(negedge clk);
            total_n++;
            if ({valid_out, data_out} !== {1'b1, exp[k]}) $display("FAIL rr_word%0d: got %h want %h", k, {valid_out, data_out}, {1'b1, exp[k]});
            else pass_n++;
        end
        @(negedge clk);
        total_n++;
        if ({count_D0, count_D1, idle_out, valid_out} !== {8'd2, 8'd2, 2'b10}) $display("FAIL rr_end: got %h want %h", {count_D0, count_D1, idle_out, valid_out}, {8'd2, 8'd2, 2'b10});
        else pass_n++;
    endtask

    task automatic test_backpressure();
        do_reset();
        push0(6'h03);
        push1(6'h13);
        enable = 1'b1;
        ready_in = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            total_n++;
            if ({valid_out, data_out, D0_pop, D1_pop} !== {1'b1, 6'h03, 2'b00}) $display("FAIL bp_hold%0d: got %h want %h", k, {valid_out, data_out, D0_pop, D1_pop}, {1'b1, 6'h03, 2'b00});
            else pass_n++;
            @(negedge clk);
        end
        ready_in = 1'b1;
        #1;
        total_n++;
        if ({valid_out, D0_pop, D1_pop} !== 3'b101) $display("FAIL bp_release: got %b want 101", {valid_out, D0_pop, D1_pop});
        else pass_n++;
        @(negedge clk);
        total_n++;
        if (valid_out !== 1'b0) $display("FAIL bp_gap: got %b want 0", valid_out);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if ({valid_out, dest_out, data_out} !== {2'b11, 6'h13}) $display("FAIL bp_next: got %h want %h", {valid_out, dest_out, data_out}, {2'b11, 6'h13});
        else pass_n++;
    endtask

    task automatic test_route_error();
        do_reset();
        push0(6'h10);
        push0(6'h00);
        push1(6'h11);
        enable = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        total_n++;
        if (error_route !== 1'b0) $display("FAIL err_before: got %b want 0", error_route);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if ({error_route, data_out} !== {1'b1, 6'h10}) $display("FAIL err_set: got %h want %h", {error_route, data_out}, {1'b1, 6'h10});
        else pass_n++;
        repeat (6) @(negedge clk);
        total_n++;
        if ({error_route, count_D0, count_D1} !== {1'b1, 8'd2, 8'd1}) $display("FAIL err_sticky: got %h want %h", {error_route, count_D0, count_D1}, {1'b1, 8'd2, 8'd1});
        else pass_n++;
        do_reset();
        total_n++;
        if (error_route !== 1'b0) $display("FAIL err_clear: got %b want 0", error_route);
        else pass_n++;
    endtask

    task automatic test_wrap_enable();
        do_reset();
        for (int i = 0; i < 256; i++) push0(6'(i & 15));
        enable = 1'b1;
        ready_in = 1'b1;
        repeat (510) @(negedge clk);
        total_n++;
        if (count_D0 !== 8'd255) $display("FAIL wrap_255: got %0d want 255", count_D0);
        else pass_n++;
        repeat (2) @(negedge clk);
        total_n++;
        if ({count_D0, data_out} !== {8'd0, 6'h0F}) $display("FAIL wrap_0: got %h want %h", {count_D0, data_out}, {8'd0, 6'h0F});
        else pass_n++;
        @(negedge clk);
        push0(6'h01);
        push0(6'h02);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        total_n++;
        if ({valid_out, data_out, count_D0, D0_pop} !== {1'b1, 6'h01, 8'd1, 1'b0}) $display("FAIL en_deliver: got %h want %h", {valid_out, data_out, count_D0, D0_pop}, {1'b1, 6'h01, 8'd1, 1'b0});
        else pass_n++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_n++;
            if ({valid_out, D0_pop, D1_pop, count_D0} !== {3'b000, 8'd1}) $display("FAIL en_nopop%0d: got %h want %h", k, {valid_out, D0_pop, D1_pop, count_D0}, {3'b000, 8'd1});
            else pass_n++;
        end
        mask0 = 1'b1;
        enable = 1'b1;
        #1;
        total_n++;
        if (D0_pop !== 1'b0) $display("FAIL empty_same_cycle: got %b want 0", D0_pop);
        else pass_n++;
        mask0 = 1'b0;
        #1;
        total_n++;
        if (D0_pop !== 1'b1) $display("FAIL en_resume: got %b want 1", D0_pop);
        else pass_n++;
        repeat (2) @(negedge clk);
        total_n++;
        if ({valid_out, data_out} !== {1'b1, 6'h02}) $display("FAIL en_word: got %h want %h", {valid_out, data_out}, {1'b1, 6'h02});
        else pass_n++;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        push0(6'h10);
        push1(6'h11);
        enable = 1'b1;
        ready_in = 1'b0;
        repeat (2) @(negedge clk);
        total_n++;
        if ({valid_out, error_route, count_D0} !== {2'b11, 8'd1}) $display("FAIL mid_pre: got %h want %h", {valid_out, error_route, count_D0}, {2'b11, 8'd1});
        else pass_n++;
        #2;
        reset = 1'b1;
        #1;
        total_n++;
        if ({valid_out, error_route, count_D0, count_D1, D0_pop, D1_pop} !== 20'h0) $display("FAIL mid_reset: got %h want 0", {valid_out, error_route, count_D0, count_D1, D0_pop, D1_pop});
        else pass_n++;
        w0 = 0;
        w1 = 0;
        @(negedge clk);
        reset = 1'b0;
        push1(6'h15);
        push0(6'h05);
        #1;
        total_n++;
        if ({D0_pop, D1_pop} !== 2'b10) $display("FAIL mid_tie: got %b want 10", {D0_pop, D1_pop});
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_route_error();
        test_wrap_enable();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
